// File: rtl/cu_pkg.sv
// Shared definitions for the control sequencer: FSM states, control-word
// field positions and the fixed control-word values.
package cu_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

  localparam int CW_W = 33;

  localparam int ALU_EN    = 32;
  localparam int ALU_BS    = 31;
  localparam int ALU_FS_HI = 30;
  localparam int ALU_FS_LO = 26;
  localparam int RF_B_EN   = 25;
  localparam int RF_SA_HI  = 24;
  localparam int RF_SA_LO  = 20;
  localparam int RF_SB_HI  = 19;
  localparam int RF_SB_LO  = 15;
  localparam int RF_DA_HI  = 14;
  localparam int RF_DA_LO  = 10;
  localparam int RF_W      = 9;
  localparam int RAM_EN    = 8;
  localparam int RAM_W     = 7;
  localparam int PC_EN     = 6;
  localparam int PC_FS_HI  = 5;
  localparam int PC_FS_LO  = 4;
  localparam int PC_IS     = 3;
  localparam int STATUS_LD = 2;
  localparam int NS_HI     = 1;
  localparam int NS_LO     = 0;

  localparam logic [1:0] PC_FS_HOLD = 2'b00;
  localparam logic [1:0] PC_FS_INC  = 2'b01;

  localparam logic [CW_W-1:0] NOP_CW = '0;

endpackage

// File: rtl/cw_gate.sv
// Combinational control-word selection: NOP in HALT, PC step in FETCH,
// decoder word in EXEC with state-changing fields masked during a memory stall.
module cw_gate
  import cu_pkg::*;
(
  input  state_e            state,
  input  logic [CW_W-1:0]   cw_dec,
  input  logic              mem_ready,
  output logic [CW_W-1:0]   cw,
  output logic              fetch_req,
  output logic              stall
);

  always_comb begin
    cw        = NOP_CW;
    fetch_req = 1'b0;
    stall     = 1'b0;
    case (state)
      ST_FETCH: begin
        fetch_req = 1'b1;
        cw[PC_FS_HI:PC_FS_LO] = mem_ready ? PC_FS_INC : PC_FS_HOLD;
      end
      ST_EXEC: begin
        cw    = cw_dec;
        stall = (cw_dec[RAM_EN] | cw_dec[RAM_W]) & ~mem_ready;
        // RAM strobes stay up so the access can complete; nothing else commits
        if (stall) begin
          cw[RF_W]              = 1'b0;
          cw[STATUS_LD]         = 1'b0;
          cw[PC_FS_HI:PC_FS_LO] = PC_FS_HOLD;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Instruction sequencer: HALT/FETCH/EXEC FSM holding IR, phase, status flags
// and a retired-instruction counter; control word comes from cw_gate.
module control_sequencer
  import cu_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              run,
  input  logic              mem_ready,
  input  logic [31:0]       instr_in,
  input  logic [CW_W-1:0]   cw_dec,
  input  logic [4:0]        alu_status,
  output logic [31:0]       ir,
  output logic [1:0]        phase,
  output logic [4:0]        status,
  output logic [CW_W-1:0]   cw,
  output logic              fetch_req,
  output logic              halted,
  output logic [15:0]       instr_count
);

  state_e      state_q, state_d;
  logic [31:0] ir_q;
  logic [1:0]  phase_q;
  logic [4:0]  status_q;
  logic [15:0] cnt_q;
  logic        stall;
  logic        advance;
  logic        retire;

  cw_gate u_cw_gate (
    .state     (state_q),
    .cw_dec    (cw_dec),
    .mem_ready (mem_ready),
    .cw        (cw),
    .fetch_req (fetch_req),
    .stall     (stall)
  );

  assign advance = (state_q == ST_EXEC) && !stall;
  assign retire  = advance && (cw_dec[NS_HI:NS_LO] == 2'b00);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_HALT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT:  if (run)       state_d = ST_FETCH;
      ST_FETCH: if (mem_ready) state_d = ST_EXEC;
      ST_EXEC:  if (retire)    state_d = run ? ST_FETCH : ST_HALT;
      default:                 state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ir_q     <= '0;
      phase_q  <= '0;
      status_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (state_q == ST_FETCH && mem_ready) begin
        ir_q    <= instr_in;
        phase_q <= 2'b00;
      end
      if (advance) begin
        if (cw_dec[STATUS_LD])             status_q <= alu_status;
        if (cw_dec[NS_HI:NS_LO] != 2'b00)  phase_q  <= cw_dec[NS_HI:NS_LO];
      end
      if (retire) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign ir          = ir_q;
  assign phase       = phase_q;
  assign status      = status_q;
  assign instr_count = cnt_q;
  assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: reset, fetch wait states, retire,
// memory stall masking, multi-phase execution, counter wrap, reset mid-op.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        run;
  logic        mem_ready;
  logic [31:0] instr_in;
  logic [32:0] cw_dec;
  logic [4:0]  alu_status;
  logic [31:0] ir;
  logic [1:0]  phase;
  logic [4:0]  status;
  logic [32:0] cw;
  logic        fetch_req;
  logic        halted;
  logic [15:0] instr_count;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  control_sequencer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .run         (run),
    .mem_ready   (mem_ready),
    .instr_in    (instr_in),
    .cw_dec      (cw_dec),
    .alu_status  (alu_status),
    .ir          (ir),
    .phase       (phase),
    .status      (status),
    .cw          (cw),
    .fetch_req   (fetch_req),
    .halted      (halted),
    .instr_count (instr_count)
  );

  // Decoder words: alu_en=1, alu_fs=0A, rf_da=3 plus per-test fields
  localparam logic [32:0] CW_RETIRE_LD = 33'h1_2800_0C14; // status_ld, pc inc, ns=00
  localparam logic [32:0] CW_RETIRE    = 33'h1_2800_0C10; // pc inc, ns=00
  localparam logic [32:0] CW_RAM       = 33'h1_2800_0F15; // ram_en, rf_w, pc inc, status_ld, ns=01
  localparam logic [32:0] CW_RAM_STALL = 33'h1_2800_0D01; // same, rf_w/status_ld/pc_fs cleared
  localparam logic [32:0] CW_NS1       = 33'h1_2800_0C01;
  localparam logic [32:0] CW_NS2       = 33'h1_2800_0C02;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; run = 1'b1; mem_ready = 1'b0;
    instr_in = '0; cw_dec = '0; alu_status = '0;
    #2;
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL reset_halted got=%0b exp=1", halted); end
    total++; if (cw !== 33'h0) begin bad++; $display("FAIL reset_cw got=%h exp=0", cw); end
    total++; if (fetch_req !== 1'b0) begin bad++; $display("FAIL reset_fetch_req got=%0b exp=0", fetch_req); end
    total++; if ({ir, phase, status, instr_count} !== 55'h0) begin bad++;
      $display("FAIL reset_regs ir=%h phase=%0d status=%b cnt=%h exp all 0", ir, phase, status, instr_count); end
    tick(); tick();
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL reset_held_halted got=%0b exp=1", halted); end
    reset_n = 1'b1;
    tick();
    total++; if (fetch_req !== 1'b1 || halted !== 1'b0) begin bad++;
      $display("FAIL release_fetch fetch_req=%0b halted=%0b exp 1/0", fetch_req, halted); end
  endtask

  task automatic test_fetch();
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (cw !== 33'h0 || fetch_req !== 1'b1) begin bad++;
        $display("FAIL fetch_wait%0d cw=%h fetch_req=%0b exp 0/1", i, cw, fetch_req); end
      tick();
    end
    mem_ready = 1'b1; instr_in = 32'h8B02_0020;
    #1;
    total++; if (cw !== 33'h10) begin bad++; $display("FAIL fetch_inc cw=%h exp=10", cw); end
    tick();
    total++; if (ir !== 32'h8B02_0020 || phase !== 2'b00) begin bad++;
      $display("FAIL fetch_load ir=%h phase=%0d exp 8b020020/0", ir, phase); end
    total++; if (fetch_req !== 1'b0) begin bad++; $display("FAIL fetch_done fetch_req=%0b exp=0", fetch_req); end
  endtask

  task automatic test_exec_retire();
    mem_ready = 1'b0; cw_dec = CW_RETIRE_LD; alu_status = 5'b10010; run = 1'b1;
    #1;
    total++; if (cw !== CW_RETIRE_LD) begin bad++; $display("FAIL exec_cw got=%h exp=%h", cw, CW_RETIRE_LD); end
    tick();
    total++; if (status !== 5'b10010) begin bad++; $display("FAIL exec_status got=%b exp=10010", status); end
    total++; if (instr_count !== 16'd1) begin bad++; $display("FAIL exec_count got=%h exp=1", instr_count); end
    total++; if (fetch_req !== 1'b1) begin bad++; $display("FAIL exec_next_fetch got=%0b exp=1", fetch_req); end
  endtask

  task automatic test_stall();
    mem_ready = 1'b1; instr_in = 32'h1234_5678;
    tick();
    mem_ready = 1'b0; cw_dec = CW_RAM; alu_status = 5'b00111;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (cw !== CW_RAM_STALL) begin bad++; $display("FAIL stall_cw%0d got=%h exp=%h", i, cw, CW_RAM_STALL); end
      tick();
      total++; if (phase !== 2'b00 || status !== 5'b10010 || fetch_req !== 1'b0) begin bad++;
        $display("FAIL stall_hold%0d phase=%0d status=%b fetch_req=%0b exp 0/10010/0", i, phase, status, fetch_req); end
    end
    mem_ready = 1'b1;
    #1;
    total++; if (cw !== CW_RAM) begin bad++; $display("FAIL stall_release_cw got=%h exp=%h", cw, CW_RAM); end
    tick();
    total++; if (phase !== 2'b01 || status !== 5'b00111) begin bad++;
      $display("FAIL stall_advance phase=%0d status=%b exp 1/00111", phase, status); end
    cw_dec = CW_RETIRE;
    tick();
    total++; if (instr_count !== 16'd2 || fetch_req !== 1'b1) begin bad++;
      $display("FAIL stall_retire cnt=%h fetch_req=%0b exp 2/1", instr_count, fetch_req); end
  endtask

  task automatic test_phase_seq();
    mem_ready = 1'b1; cw_dec = CW_NS1;
    tick();
    total++; if (phase !== 2'b00) begin bad++; $display("FAIL seq_phase0 got=%0d exp=0", phase); end
    tick();
    total++; if (phase !== 2'b01) begin bad++; $display("FAIL seq_phase1 got=%0d exp=1", phase); end
    run = 1'b0; cw_dec = CW_NS2;
    tick();
    total++; if (phase !== 2'b10 || halted !== 1'b0) begin bad++;
      $display("FAIL seq_phase2 phase=%0d halted=%0b exp 2/0", phase, halted); end
    cw_dec = CW_RETIRE;
    tick();
    total++; if (halted !== 1'b1 || cw !== 33'h0 || fetch_req !== 1'b0) begin bad++;
      $display("FAIL seq_halt halted=%0b cw=%h fetch_req=%0b exp 1/0/0", halted, cw, fetch_req); end
    total++; if (instr_count !== 16'd3) begin bad++; $display("FAIL seq_count got=%h exp=3", instr_count); end
    tick();
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL seq_stay_halt got=%0b exp=1", halted); end
  endtask

  task automatic test_wrap();
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    run = 1'b1; mem_ready = 1'b1; cw_dec = CW_RETIRE;
    tick();
    tick();
    total++; if (instr_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_pre got=%h exp=ffff", instr_count); end
    tick();
    total++; if (instr_count !== 16'h0000 || fetch_req !== 1'b1) begin bad++;
      $display("FAIL wrap_post cnt=%h fetch_req=%0b exp 0000/1", instr_count, fetch_req); end
  endtask

  task automatic test_reset_mid();
    instr_in = 32'hDEAD_BEEF;
    tick();
    cw_dec = CW_RETIRE_LD; alu_status = 5'b11111;
    total++; if (ir !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mid_ir got=%h exp=deadbeef", ir); end
    #1 reset_n = 1'b0;
    #1;
    total++; if ({ir, phase, status, instr_count} !== 55'h0) begin bad++;
      $display("FAIL mid_regs ir=%h phase=%0d status=%b cnt=%h exp all 0", ir, phase, status, instr_count); end
    total++; if (cw !== 33'h0 || halted !== 1'b1 || fetch_req !== 1'b0) begin bad++;
      $display("FAIL mid_outs cw=%h halted=%0b fetch_req=%0b exp 0/1/0", cw, halted, fetch_req); end
    tick();
    total++; if (instr_count !== 16'h0 || status !== 5'h0) begin bad++;
      $display("FAIL mid_held cnt=%h status=%b exp 0/0", instr_count, status); end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_exec_retire();
    test_stall();
    test_phase_seq();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; the ports are named clock and reset_n.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 run  input  1  1 = execute; sampled at instruction completion and in HALT.
REQ-005 mem_ready  input  1  instruction fetch or RAM access completes this cycle.
REQ-006 instr_in  input  32  instruction word from memory bus.
REQ-007 cw_dec  input  33  control word from the selected instruction decoder for current IR and phase.
REQ-008 alu_status  input  5  flags from ALU.
REQ-009 ir  output  32  instruction register, drives decoders.
REQ-010 phase  output  2  execute sub-state, drives decoder state input.
REQ-011 status  output  5  registered flags, drives decoder status input.
REQ-012 cw  output  33  control word to datapath.
REQ-013 fetch_req  output  1  instruction fetch in progress.
REQ-014 halted  output  1  FSM in HALT.
REQ-015 instr_count  output  16  retired-instruction counter.

Function
REQ-016 Control-word fields SHALL be [32] alu_en, [31] alu_bs, [30:26] alu_fs, [25] rf_b_en, [24:20] rf_sa, [19:15] rf_sb, [14:10] rf_da, [9] rf_w, [8] ram_en, [7] ram_w, [6] pc_en, [5:4] pc_fs, [3] pc_is, [2] status_ld, [1:0] next_state.
REQ-017 FSM states SHALL be HALT, FETCH, EXEC.
REQ-018 HALT: cw = NOP_CW (all zero), halted=1; run=1 moves to FETCH next cycle.
REQ-019 FETCH: fetch_req=1; cw = NOP_CW except pc_fs = PC_FS_INC (01) in the cycle mem_ready=1, else PC_FS_HOLD (00).
REQ-020 FETCH with mem_ready=1: ir <= instr_in, phase <= 00, move to EXEC; fetch latency is one cycle minimum and unbounded while mem_ready=0.
REQ-021 EXEC: cw = cw_dec unless stalled.
REQ-022 Stall: EXEC with cw_dec ram_en or ram_w set and mem_ready=0; cw = cw_dec with rf_w=0, status_ld=0, pc_fs=PC_FS_HOLD; ram_en/ram_w pass through; state, phase, status unchanged.
REQ-023 Advance: EXEC not stalled; if cw_dec status_ld=1, status <= alu_status.
REQ-024 Advance with cw_dec next_state != 00: phase <= next_state, remain EXEC.
REQ-025 Advance with next_state == 00: instruction retires; instr_count <= instr_count+1 (wraps FFFF->0000); run=1 -> FETCH, run=0 -> HALT.
REQ-026 run deassertion during FETCH or mid-instruction SHALL NOT abort it; it takes effect at retirement.
REQ-027 cw and fetch_req SHALL be combinational from state, cw_dec and mem_ready; all other outputs registered.

Reset
REQ-028 reset_n=0 SHALL immediately force state=HALT, ir=0, phase=00, status=00000, instr_count=0, hence cw=NOP_CW, fetch_req=0, halted=1.
REQ-029 Reset mid-instruction SHALL abandon it without incrementing instr_count or loading status.

Structure
REQ-030 Shared package cu_pkg SHALL hold the state enum, control-word field bit positions, PC_FS_HOLD, PC_FS_INC and NOP_CW.
REQ-031 One sub-module, cw_gate, SHALL implement the combinational cw selection/stall masking; the FSM and registers stay in control_sequencer.

Verification
REQ-032 Reset with run=1 -> halted=1, cw=0; after release, FETCH next cycle, fetch_req=1.
REQ-033 FETCH, mem_ready=0 for 3 cycles then 1 with instr_in=32'h8B020020 -> pc_fs=00 for 3 cycles, 01 on 4th; ir=8B020020, phase=00 next cycle.
REQ-034 EXEC, cw_dec next_state=00, status_ld=1, alu_status=5'b10010 -> status=10010, instr_count+1, FETCH next.
REQ-035 EXEC, cw_dec ram_en=1, rf_w=1, mem_ready=0 for 2 cycles -> cw rf_w=0, pc_fs=00, phase held; mem_ready=1 -> rf_w=1 passes, advance.
REQ-036 cw_dec next_state sequence 01,10,00 -> phase 00,01,10 then retire; run dropped during phase 01 -> HALT after retirement, halted=1.
REQ-037 instr_count=FFFF, retire one instruction -> 0000; reset_n pulsed during EXEC -> all outputs per REQ-028 within the same cycle.
